// File: rtl/pic_pkg.sv
// pic_pkg: shared definitions for the picture loader.
//   SYNC_BYTE   - frame start marker accepted in IDLE
//   ADDR_W      - frame-buffer write address width
//   pic_state_e - loader FSM states. StCheck exists only when PIC_LOADER_CSUM_EN is defined.
package pic_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
`ifdef PIC_LOADER_CSUM_EN
    StCheck = 2'd2,
`endif
    StDone  = 2'd3
  } pic_state_e;

endpackage

// File: rtl/pic_timeout.sv
// pic_timeout: idle-cycle watchdog for the picture loader.
//   clk       - clock
//   rst       - synchronous active-high reset
//   enable_i  - count idle cycles while high
//   clear_i   - restart from zero; takes priority over enable_i
//   expired_o - high while enabled and TIMEOUT idle cycles have elapsed
module pic_timeout #(
  parameter int unsigned TIMEOUT = 40000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned      CntW  = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_limit;

  assign at_limit  = (cnt_q == Limit);
  assign expired_o = enable_i && at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !at_limit) begin
      // Saturate at the limit so the counter never wraps.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pic_loader.sv
// pic_loader: loads one picture from a byte stream into an external frame-buffer RAM.
// A SYNC byte in IDLE starts a frame of PIX_NUM pixel bytes, each written one cycle after
// acceptance at consecutive addresses from 0. An idle gap of TIMEOUT cycles mid-load aborts
// with err set. Optional checksum: define PIC_LOADER_CSUM_EN to require a trailing XOR byte.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   s_data/s_valid     - input byte stream; s_ready - byte accepted this cycle when valid
//   wr_en/wr_addr/wr_data - RAM write port
//   busy               - load in progress; frame_done - one-cycle pulse on success
//   err                - sticky error, cleared by the next SYNC or reset
module pic_loader
  import pic_pkg::*;
#(
  parameter int unsigned PIX_NUM = 40000,
  parameter int unsigned TIMEOUT = 40000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(PIX_NUM - 1);

  pic_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              err_q, err_d;
  logic              accept;
  logic              expired;
`ifdef PIC_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign s_ready    = !rst && (state_q != StDone);
  assign accept     = s_valid && s_ready;
`ifdef PIC_LOADER_CSUM_EN
  assign busy       = (state_q == StLoad) || (state_q == StCheck);
`else
  assign busy       = (state_q == StLoad);
`endif
  assign frame_done = (state_q == StDone);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign err        = err_q;

  // Idle counter only runs while loading; any accepted byte restarts it.
  pic_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (busy),
    .clear_i   (accept || !busy),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef PIC_LOADER_CSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept && (s_data == SYNC_BYTE)) begin
          state_d = StLoad;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef PIC_LOADER_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLoad: begin
        // Acceptance wins over a coincident timeout; 0xA5 here is ordinary pixel data.
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = s_data;
`ifdef PIC_LOADER_CSUM_EN
          csum_d    = csum_q ^ s_data;
`endif
          if (cnt_q == LastPix) begin
`ifdef PIC_LOADER_CSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
`ifdef PIC_LOADER_CSUM_EN
      StCheck: begin
        if (accept) begin
          if (s_data == csum_q) begin
            state_d = StDone;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef PIC_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef PIC_LOADER_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_pic_loader.sv
// tb_pic_loader: randomized self-checking bench for pic_loader.
// Expected writes are the pixel list sent, at addresses 0..PixNum-1 in order.
// Checksum scenarios run when PIC_LOADER_CSUM_EN is defined.
module tb_pic_loader;

  localparam int unsigned PixNum     = 1000;
  localparam int unsigned TimeoutCyc = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;
  logic        err;

  always #5 clk = ~clk;

  pic_loader #(
    .PIX_NUM (PixNum),
    .TIMEOUT (TimeoutCyc)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write/pulse monitor, sampled mid-cycle.
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          fd_cnt      = 0;
  int          fd_rdy_bad  = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      if (s_ready !== 1'b0) fd_rdy_bad++;
    end
  end

  logic [7:0] pix[PixNum];
  int         gap_max = 0;

  task automatic clear_mon();
    @(posedge clk);
    #1;
    wa_q.delete();
    wd_q.delete();
    fd_cnt     = 0;
    fd_rdy_bad = 0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_wait", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
  endtask

  task automatic send_frame(input bit bad_csum);
    logic [7:0] csum = 8'h00;
    send_byte(8'hA5);
    check("busy_after_sync", busy, 1);
    for (int i = 0; i < PixNum; i++) begin
      send_byte(pix[i]);
      csum ^= pix[i];
    end
`ifdef PIC_LOADER_CSUM_EN
    send_byte(bad_csum ? (csum ^ 8'h01) : csum);
`else
    if (bad_csum) csum = 8'h00;
`endif
    repeat (4) @(negedge clk);
  endtask

  task automatic verify_frame(input string tag, input int exp_fd, input logic exp_err);
    int bad  = 0;
    int maxa = 0;
    check({tag, "_wr_count"}, wa_q.size(), PixNum);
    for (int i = 0; i < wa_q.size(); i++) begin
      if (i >= PixNum || wa_q[i] !== 16'(i) || wd_q[i] !== pix[i]) bad++;
      if (int'(wa_q[i]) > maxa) maxa = int'(wa_q[i]);
    end
    check({tag, "_wr_seq_bad"}, bad, 0);
    check({tag, "_addr_max"}, maxa, PixNum - 1);
    if (wa_q.size() > 0) check({tag, "_first_addr"}, wa_q[0], 0);
    check({tag, "_frame_done_cnt"}, fd_cnt, exp_fd);
    check({tag, "_done_ready_low"}, fd_rdy_bad, 0);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", s_ready, 1);

    // Garbage before SYNC is ignored; incrementing pattern, back-to-back bytes.
    for (int i = 0; i < PixNum; i++) pix[i] = 8'(i % 256);
    clear_mon();
    send_byte(8'h11);
    send_byte(8'h22);
    check("pre_sync_busy", busy, 0);
    send_frame(1'b0);
    verify_frame("incr", 1, 1'b0);
    if (wd_q.size() == PixNum) check("incr_last_data", wd_q[PixNum-1], 8'((PixNum - 1) % 256));

    // Random data, random s_valid gaps, 0xA5 planted as pixel 7.
    for (int i = 0; i < PixNum; i++) pix[i] = 8'($urandom);
    pix[7]  = 8'hA5;
    gap_max = 2;
    clear_mon();
    send_frame(1'b0);
    verify_frame("rand", 1, 1'b0);
    if (wd_q.size() > 7) check("rand_pix7", wd_q[7], 8'hA5);

    // Timeout after 100 pixels.
    gap_max = 0;
    clear_mon();
    send_byte(8'hA5);
    for (int i = 0; i < 100; i++) send_byte(pix[i]);
    repeat (TimeoutCyc - 10) @(negedge clk);
    check("to_busy_before", busy, 1);
    check("to_err_before", err, 0);
    repeat (20) @(negedge clk);
    check("to_busy_after", busy, 0);
    check("to_err_after", err, 1);
    check("to_frame_done", fd_cnt, 0);
    check("to_wr_count", wa_q.size(), 100);
    send_byte(8'hA5);
    check("to_err_cleared_by_sync", err, 0);
    check("to_busy_resync", busy, 1);

    // Reset mid-load at pixel 500.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    send_byte(8'hA5);
    for (int i = 0; i < 500; i++) send_byte(pix[i]);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_500");
    rst = 1'b0;
    @(negedge clk);
    check("rst_500_writes", wa_q.size(), 500);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (3) @(negedge clk);
    check("rst_no_resume_writes", wa_q.size(), 500);
    check("rst_no_pulse", fd_cnt, 0);
    check("rst_idle_busy", busy, 0);
    gap_max = 1;
    clear_mon();
    send_frame(1'b0);
    verify_frame("after_rst", 1, 1'b0);

`ifdef PIC_LOADER_CSUM_EN
    // Bad checksum: all pixels written, no pulse, err set; then a good frame.
    clear_mon();
    send_frame(1'b1);
    verify_frame("bad_csum", 0, 1'b1);
    clear_mon();
    send_frame(1'b0);
    verify_frame("good_csum", 1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pic_loader.md
PIC_LOADER -- requirements
Module: pic_loader

Interface
REQ-001 SHALL have parameter PIX_NUM, default 40000, meaning pixels per picture (200x200, RGB332).
REQ-002 SHALL have parameter TIMEOUT, default 40000000, meaning idle clk cycles tolerated mid-load (1 s at 40 MHz).
REQ-003 SHALL have port clk  input  1  pixel-domain clock (40 MHz), shared with the VGA controller.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port s_data  input  8  incoming byte stream (e.g. from the UART receiver).
REQ-006 SHALL have port s_valid  input  1  s_data valid.
REQ-007 SHALL have port s_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port wr_en  output  1  frame-buffer RAM write strobe.
REQ-009 SHALL have port wr_addr  output  16  RAM write address, same map as the VGA read address.
REQ-010 SHALL have port wr_data  output  8  RGB332 pixel written.
REQ-011 SHALL have port busy  output  1  load in progress.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse on successful load.
REQ-013 SHALL have port err  output  1  sticky error flag, cleared by the next SYNC byte or by reset.

Function
REQ-014 SHALL accept a byte only on cycles where s_valid and s_ready are both high.
REQ-015 SHALL implement the FSM states IDLE, LOAD, CHECK and DONE.
REQ-016 IDLE: s_ready=1; SHALL discard every byte except SYNC=0xA5, which moves to LOAD, sets the pixel counter to 0 and clears err.
REQ-017 LOAD: each accepted byte SHALL produce, on the next cycle, wr_en=1, wr_addr=counter and wr_data=byte (latency 1), then increment the counter.
REQ-018 When the accepted byte is pixel PIX_NUM-1, the FSM SHALL go to CHECK (macro defined) or DONE (macro undefined).
REQ-019 The counter SHALL never wrap; wr_addr SHALL never exceed PIX_NUM-1.
REQ-020 DONE SHALL last one cycle: frame_done=1, s_ready=0, then IDLE.
REQ-021 The idle counter SHALL reset on every accepted byte and run only in LOAD/CHECK.
REQ-022 Idle counter reaching TIMEOUT SHALL set err=1 and return to IDLE with no frame_done; written pixels stay in RAM.
REQ-023 A byte 0xA5 in LOAD SHALL be treated as pixel data, not as a resync.
REQ-024 busy SHALL be 1 in LOAD and CHECK, and 0 otherwise.
REQ-025 s_ready SHALL be 1 in IDLE, LOAD and CHECK, and 0 in DONE.
REQ-026 A timeout and a byte acceptance in the same cycle: acceptance SHALL win and the idle counter SHALL reset.

Reset
REQ-027 On rst=1 at a clk edge, the FSM SHALL go to IDLE, and the counters and checksum SHALL clear.
REQ-028 Output reset values: s_ready=0 during reset and 1 on the first cycle after; wr_en=0; wr_addr=0; wr_data=0; busy=0; frame_done=0; err=0.
REQ-029 Reset mid-LOAD SHALL abort without a pulse, and a fresh SYNC SHALL be required.

Configuration
REQ-030 With PIC_LOADER_CSUM_EN defined: XOR of all pixel bytes SHALL be accumulated; CHECK SHALL accept one byte; match goes to DONE; mismatch sets err=1 and goes to IDLE with no frame_done.
REQ-031 With PIC_LOADER_CSUM_EN undefined: the CHECK state and the accumulator SHALL be absent, and LOAD SHALL go directly to DONE.

Structure
REQ-032 Shared package pic_pkg SHALL hold SYNC_BYTE (0xA5), the FSM state enum and ADDR_W (16).
REQ-033 The idle timeout counter SHALL be a sub-module, pic_timeout (enable, clear, expired).
REQ-034 The RAM SHALL be external and dual-port; this block drives only the write port.

Verification
REQ-035 SYNC then 40000 bytes of value i%256, macro off -> 40000 writes, addr 0..39999, last data 0x3F, single frame_done, err=0.
REQ-036 Bytes 0x11, 0x22, then SYNC, then a frame -> 0x11/0x22 ignored, first write addr 0.
REQ-037 SYNC, 100 pixels, then no s_valid for TIMEOUT cycles (bench TIMEOUT=50) -> err=1, IDLE, no frame_done, busy=0.
REQ-038 Macro on, full frame plus correct XOR -> frame_done; same frame with checksum XOR 0x01 -> err=1, no frame_done.
REQ-039 rst asserted at pixel 500 -> all outputs at reset values next cycle; following SYNC+frame loads from addr 0.
REQ-040 s_valid toggled randomly with a 0xA5 pixel at addr 7 -> addr 7 holds 0xA5, no resync, write count exact.
